fetch_align: RTL and testbench
==============================

Name: fetch_align

Overview:
Instruction alignment buffer between the fetch interface and decode, which feeds hazard stage.
- Accepts 64-bit fetch words containing mixed RVC (16-bit) and 32-bit instructions, stores them as halfwords, and presents up to two aligned raw instructions per cycle with their PCs.
- Absorbs downstream stall (hazard stall routed through decode) with fetch backpressure.
- Flushes on clear (redirect/exception).

Parameters:
BUF_DEPTH, 16, halfword entries in circular buffer; power of two, >= 8.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
clear  in  1  flush buffer (redirect)
stall  in  1  downstream cannot accept outputs this cycle
fetch_valid  in  1  fetch word present
fetch_pc  in  32  byte address of the fetch word; bits [2:1] give the first valid halfword
fetch_rdata  in  64  four halfwords, halfword 0 in [15:0]
fetch_ready  out  1  buffer can accept a fetch word this cycle
instr0_valid  out  1  slot 0 holds a complete instruction
instr0_pc  out  32  PC of slot 0
instr0_data  out  32  raw instruction, upper 16 bits zero if RVC
instr0_rvc  out  1  slot 0 is compressed
instr1_valid, instr1_pc, instr1_data, instr1_rvc  out  1/32/32/1  same for slot 1 (the next sequential instruction)

Behaviour:
- Reset is synchronous and active-low, on reset==0 at posedge clock. It forces: rptr=wptr=0, count=0, head_pc=0, pc_valid=0.
  - Outputs after reset: instr*_valid=0, instr*_pc=0, instr*_data=0, instr*_rvc=0, fetch_ready=1.
  - Reset mid-operation discards all content.
- State:
  - wptr, rptr: log2(BUF_DEPTH) bits, wrap modulo BUF_DEPTH.
  - count: log2(BUF_DEPTH)+1 bits.
  - head_pc: PC of the halfword at rptr.
  - pc_valid.
- fetch_ready = (count <= BUF_DEPTH-4) & ~clear. It is computed from the registered count, so no combinational path from stall.
- Write, when fetch_valid & fetch_ready:
  - Halfwords k = fetch_pc[2:1]..3 are written at wptr, wptr+1, ...; n_wr = 4 - fetch_pc[2:1].
  - If pc_valid==0, head_pc <= fetch_pc and pc_valid <= 1.
  - Fetch supplies sequential addresses between clears; no PC check is done.
- Output decode is combinational from registered buffer state only. A written halfword is first visible the cycle after the write; there is no write-to-output bypass.
  - Slot 0: hw0 = buf[rptr]. rvc0 = (hw0[1:0] != 2'b11); size0 = 1 if rvc0, else 2. instr0_valid = count >= size0.
  - Slot 1: starts at rptr+size0. rvc1 is derived the same way. instr1_valid = instr0_valid & (count >= size0+size1).
  - instr0_pc = head_pc; instr1_pc = head_pc + 2*size0.
  - A 32-bit instruction whose upper half is not yet written reports valid=0 until that half arrives.
  - Invalid slots drive data=0, pc=0, rvc=0.
- Consume, when ~stall & ~clear:
  - n_rd = (instr0_valid ? size0 : 0) + (instr1_valid ? size1 : 0).
  - rptr += n_rd; head_pc += 2*n_rd.
- Count update: count_next = count + n_wr - n_rd. Simultaneous write and consume is allowed; the fetch_ready margin guarantees no overflow.
- stall=1 holds all outputs stable and removes nothing. Writes still proceed while fetch_ready=1.
- clear=1 (highest priority after reset):
  - Next state is rptr=wptr=0, count=0, pc_valid=0.
  - Any fetch word presented in the same cycle is dropped; fetch_ready=0 that cycle.
  - Outputs in the clear cycle reflect old state; downstream ignores them.
- Wrap-around: all pointer arithmetic is modulo BUF_DEPTH. A 32-bit instruction may straddle entry BUF_DEPTH-1 and entry 0.
- Width rules: PC arithmetic is 32-bit and wraps. size0/size1 are 2 bits; n_rd is at most 4.

Decomposition:
- Shared package fetch_align_wires holds:
  - fetch_align_buf_in_type: wen, waddr, wmask[3:0], wdata[63:0], raddr.
  - fetch_align_buf_out_type: four consecutive halfwords from raddr.
  - Localparam depth = $clog2(BUF_DEPTH).
- Sub-module fetch_align_buf holds the halfword array. It has one 4-halfword masked write port at waddr..waddr+3 and a combinational read of 4 halfwords at raddr..raddr+3, both with wrap.
- Control lives in fetch_align_ctrl, in the same v/r/rin register-record style as the rest of the pipeline. Top-level fetch_align instantiates both.

Test Plan:
- Reset, then fetch pc=0x100 with four RVC halfwords (0x0001 pattern) → next cycle slot0 pc=0x100, slot1 pc=0x102, both rvc=1; then slot0 pc=0x104, slot1 pc=0x106; count returns to 0.
- Fetch pc=0x200 with two 32-bit instrs (0x00000013, 0x00100093) → next cycle both valid, pc 0x200/0x204, data matches, rvc=0.
- Straddle and redirect:
  - Fetch pc=0x306 whose halfword 3 = 0x0013 (32-bit lower) → instr0_valid=0.
  - Next word pc=0x308 with hw0=0x0000 → instr0 pc=0x306, data=0x00000013.
- Hold stall=1 while feeding words → fetch_ready deasserts when count > BUF_DEPTH-4 (after 4 full words at depth 16), outputs stable, no halfword lost or duplicated after release.
- clear asserted with count=10 and a simultaneous fetch → next cycle count=0, all valids 0; next fetch pc=0x402 yields slot0 pc=0x402.
- Pointer wrap: stream 40 sequential RVC/32-bit mixed instructions through depth 16 → PCs strictly sequential, data matches golden model.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// fetch_align_wires: shared types for the fetch alignment buffer.
//   BUF_DEPTH                 halfword entries in the circular buffer (power of two, >= 8)
//   depth                     pointer width, $clog2(BUF_DEPTH)
//   fetch_align_buf_in_type   write port (wen/waddr/wmask/wdata) and read address
//   fetch_align_buf_out_type  four consecutive halfwords starting at raddr
//   fetch_align_reg_type      control register record
package fetch_align_wires;

  localparam int BUF_DEPTH = 16;
  localparam int depth     = $clog2(BUF_DEPTH);

  typedef logic [depth-1:0] ptr_t;
  typedef logic [depth:0]   cnt_t;

  typedef struct packed {
    logic        wen;
    ptr_t        waddr;
    logic [3:0]  wmask;   // bit j writes wdata[16j +: 16] to waddr+j
    logic [63:0] wdata;
    ptr_t        raddr;
  } fetch_align_buf_in_type;

  typedef struct packed {
    logic [3:0][15:0] hw;  // hw[j] = entry raddr+j
  } fetch_align_buf_out_type;

  typedef struct packed {
    ptr_t        wptr;
    ptr_t        rptr;
    cnt_t        count;
    logic [31:0] head_pc;   // PC of the halfword at rptr
    logic        pc_valid;  // head_pc holds a real address
  } fetch_align_reg_type;

  // Low two bits of 2'b11 mark a 32-bit instruction; anything else is RVC.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_if.sv
// fetch_align_if: fetch-side handshake plus the two aligned instruction slots.
//   master : fetch source / decode side (drives fetch_*, observes fetch_ready and instr*)
//   slave  : the alignment buffer
interface fetch_align_if;

  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_rdata;
  logic        fetch_ready;

  logic        instr0_valid;
  logic [31:0] instr0_pc;
  logic [31:0] instr0_data;
  logic        instr0_rvc;
  logic        instr1_valid;
  logic [31:0] instr1_pc;
  logic [31:0] instr1_data;
  logic        instr1_rvc;

  modport master (
    output fetch_valid, fetch_pc, fetch_rdata,
    input  fetch_ready,
    input  instr0_valid, instr0_pc, instr0_data, instr0_rvc,
    input  instr1_valid, instr1_pc, instr1_data, instr1_rvc
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_rdata,
    output fetch_ready,
    output instr0_valid, instr0_pc, instr0_data, instr0_rvc,
    output instr1_valid, instr1_pc, instr1_data, instr1_rvc
  );

endinterface

// File: rtl/fetch_align_buf.sv
// fetch_align_buf: circular halfword storage.
//   clock : clock
//   bin   : masked 4-halfword write at waddr..waddr+3, read address
//   bout  : combinational read of entries raddr..raddr+3
// All addresses wrap modulo BUF_DEPTH.
module fetch_align_buf
  import fetch_align_wires::*;
(
  input  logic                    clock,
  input  fetch_align_buf_in_type  bin,
  output fetch_align_buf_out_type bout
);

  logic [15:0] mem [BUF_DEPTH];

  // NOTE: the array has no reset; control never presents an entry as valid
  // before it has been written, so clearing it would only cost logic.
  always_ff @(posedge clock) begin
    if (bin.wen) begin
      for (int j = 0; j < 4; j++) begin
        if (bin.wmask[j]) mem[ptr_t'(bin.waddr + ptr_t'(j))] <= bin.wdata[16*j +: 16];
      end
    end
  end

  always_comb begin
    bout = '0;
    for (int j = 0; j < 4; j++) bout.hw[j] = mem[ptr_t'(bin.raddr + ptr_t'(j))];
  end

endmodule

// File: rtl/fetch_align_ctrl.sv
// fetch_align_ctrl: pointer/count/PC bookkeeping and two-slot instruction decode.
//   clock, reset  : clock, synchronous active-low reset
//   clear         : flush (redirect); drops any same-cycle fetch word
//   stall         : downstream holds; nothing is consumed
//   fa            : fetch handshake and instruction slot outputs
//   bin / bout    : storage write/read port
module fetch_align_ctrl
  import fetch_align_wires::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    stall,
  fetch_align_if.slave            fa,
  output fetch_align_buf_in_type  bin,
  input  fetch_align_buf_out_type bout
);

  fetch_align_reg_type r, rin;

  logic [1:0]  off;
  logic        fire_wr;
  cnt_t        n_wr, n_rd;
  logic        rvc0, rvc1, v0, v1;
  logic [1:0]  size0, size1;
  logic [31:0] data0, data1;

  // NOTE: every output and the record copy are assigned before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fetch_align_reg_type v;
    v = r;

    // Ready depends only on registered count and clear: no path from stall.
    fa.fetch_ready = (r.count <= cnt_t'(BUF_DEPTH - 4)) && !clear;
    fire_wr        = fa.fetch_valid && fa.fetch_ready;

    // Shift the word so the first valid halfword lands at wptr.
    off       = fa.fetch_pc[2:1];
    n_wr      = fire_wr ? cnt_t'(3'd4 - {1'b0, off}) : '0;
    bin.wen   = fire_wr;
    bin.waddr = r.wptr;
    bin.wmask = 4'b1111 >> off;
    bin.wdata = fa.fetch_rdata >> {off, 4'b0000};
    bin.raddr = r.rptr;

    rvc0  = is_rvc(bout.hw[0]);
    size0 = rvc0 ? 2'd1 : 2'd2;
    v0    = r.count >= cnt_t'(size0);
    data0 = rvc0 ? {16'h0000, bout.hw[0]} : {bout.hw[1], bout.hw[0]};

    // Slot 1 begins right after slot 0 in the read window.
    rvc1  = is_rvc(bout.hw[size0]);
    size1 = rvc1 ? 2'd1 : 2'd2;
    v1    = v0 && (r.count >= cnt_t'(size0) + cnt_t'(size1));
    data1 = rvc1 ? {16'h0000, bout.hw[size0]} : {bout.hw[size0 + 2'd1], bout.hw[size0]};

    fa.instr0_valid = v0;
    fa.instr0_pc    = v0 ? r.head_pc : '0;
    fa.instr0_data  = v0 ? data0 : '0;
    fa.instr0_rvc   = v0 && rvc0;
    fa.instr1_valid = v1;
    fa.instr1_pc    = v1 ? r.head_pc + {29'd0, size0, 1'b0} : '0;
    fa.instr1_data  = v1 ? data1 : '0;
    fa.instr1_rvc   = v1 && rvc1;

    n_rd = (!stall && !clear)
         ? cnt_t'(v0 ? size0 : 2'd0) + cnt_t'(v1 ? size1 : 2'd0)
         : '0;

    v.rptr    = r.rptr + ptr_t'(n_rd);
    v.head_pc = r.head_pc + 32'({n_rd, 1'b0});
    v.count   = r.count + n_wr - n_rd;

    if (fire_wr) begin
      v.wptr = r.wptr + ptr_t'(n_wr);
      // Buffer is empty whenever pc_valid is 0, so nothing is consumed here.
      if (!r.pc_valid) begin
        v.head_pc  = fa.fetch_pc;
        v.pc_valid = 1'b1;
      end
    end

    if (clear) begin
      v.wptr     = '0;
      v.rptr     = '0;
      v.count    = '0;
      v.pc_valid = 1'b0;
    end

    rin = v;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) r <= '0;
    else        r <= rin;
  end

endmodule

// File: rtl/fetch_align.sv
// fetch_align: instruction alignment buffer between fetch and decode.
//   clock  : clock
//   reset  : synchronous active-low reset
//   clear  : flush on redirect/exception
//   stall  : downstream cannot accept slot outputs this cycle
//   fa     : fetch word handshake in, two aligned instruction slots out
module fetch_align
  import fetch_align_wires::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         stall,
  fetch_align_if.slave fa
);

  fetch_align_buf_in_type  bin;
  fetch_align_buf_out_type bout;

  fetch_align_ctrl u_ctrl (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .stall (stall),
    .fa    (fa),
    .bin   (bin),
    .bout  (bout)
  );

  fetch_align_buf u_buf (
    .clock (clock),
    .bin   (bin),
    .bout  (bout)
  );

endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: scoreboard bench for fetch_align. Accepted halfwords are
// pushed (with their PCs) into a model queue; each cycle the slot outputs are
// compared against the instructions the queue can form and consumed ones popped.
module tb_fetch_align;
  import fetch_align_wires::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic stall = 1'b0;

  fetch_align_if fa_if ();

  fetch_align dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .stall (stall),
    .fa    (fa_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] hw;
  } hw_t;

  hw_t         model[$];
  logic [15:0] pend[$];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  bit          rand_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare both slots against the halfword queue, then pop what is consumed.
  task automatic monitor();
    int          n, s0, s1;
    logic        e0, e1, r0, r1;
    logic [31:0] p0, p1, d0, d1;
    n = model.size();
    e0 = 0; e1 = 0; r0 = 0; r1 = 0; s0 = 0; s1 = 0;
    p0 = 0; p1 = 0; d0 = 0; d1 = 0;
    if (n >= 1) begin
      r0 = model[0].hw[1:0] != 2'b11;
      s0 = r0 ? 1 : 2;
      e0 = n >= s0;
    end
    if (e0) begin
      p0 = model[0].pc;
      if (r0) d0 = {16'h0000, model[0].hw};
      else    d0 = {model[1].hw, model[0].hw};
      if (n > s0) begin
        r1 = model[s0].hw[1:0] != 2'b11;
        s1 = r1 ? 1 : 2;
        e1 = n >= s0 + s1;
      end
    end
    if (e1) begin
      p1 = model[s0].pc;
      if (r1) d1 = {16'h0000, model[s0].hw};
      else    d1 = {model[s0+1].hw, model[s0].hw};
    end
    check("slot0_valid", fa_if.instr0_valid, e0);
    check("slot0_pc",    fa_if.instr0_pc,    p0);
    check("slot0_data",  fa_if.instr0_data,  d0);
    check("slot0_rvc",   fa_if.instr0_rvc,   e0 & r0);
    check("slot1_valid", fa_if.instr1_valid, e1);
    check("slot1_pc",    fa_if.instr1_pc,    p1);
    check("slot1_data",  fa_if.instr1_data,  d1);
    check("slot1_rvc",   fa_if.instr1_rvc,   e1 & r1);
    if (!stall && !clear) begin
      int used;
      used = (e0 ? s0 : 0) + (e1 ? s1 : 0);
      repeat (used) void'(model.pop_front());
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) monitor();
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] pc, input logic [63:0] data);
    bit acc;
    int tries = 0;
    fa_if.fetch_valid = 1'b1;
    fa_if.fetch_pc    = pc;
    fa_if.fetch_rdata = data;
    forever begin
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      acc = fa_if.fetch_ready;
      @(posedge clock);
      if (acc) begin
        for (int k = int'(pc[2:1]); k < 4; k++) begin
          hw_t h;
          h.pc = {pc[31:3], 3'b000} + 32'(2 * k);
          h.hw = data[16*k +: 16];
          model.push_back(h);
        end
      end
      #1;
      if (acc) break;
      tries++;
      if (tries > 100) begin
        check("fetch_accept_timeout", 0, 1);
        break;
      end
    end
    fa_if.fetch_valid = 1'b0;
  endtask

  task automatic gen_instrs(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] lo, hi;
      lo = 16'($urandom);
      hi = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        lo[1:0] = 2'b11;
        pend.push_back(lo);
        pend.push_back(hi);
      end else begin
        lo[1:0] = 2'($urandom_range(0, 2));
        pend.push_back(lo);
      end
    end
  endtask

  // Fill the valid halfwords of one word from the pending stream (pad with RVC).
  task automatic next_word(input logic [31:0] pc);
    logic [63:0] data;
    data = {$urandom, $urandom};
    for (int k = int'(pc[2:1]); k < 4; k++) begin
      data[16*k +: 16] = (pend.size() > 0) ? pend.pop_front() : 16'h0001;
    end
    send_word(pc, data);
  endtask

  task automatic stream(input logic [31:0] pc);
    logic [31:0] p;
    p = pc;
    while (pend.size() > 0) begin
      next_word(p);
      p = {p[31:3], 3'b000} + 32'd8;
    end
  endtask

  // Clear with a fetch word presented in the same cycle; that word must drop.
  task automatic do_clear();
    clear = 1'b1;
    fa_if.fetch_valid = 1'b1;
    fa_if.fetch_pc    = 32'h0000_0ff0;
    fa_if.fetch_rdata = {$urandom, $urandom};
    @(negedge clock);
    check("clear_fetch_ready", fa_if.fetch_ready, 0);
    @(posedge clock);
    model.delete();
    pend.delete();
    #1;
    clear = 1'b0;
    fa_if.fetch_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    rand_stall = 1'b0;
    stall = 1'b0;
    while (model.size() != 0 && c < 200) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("drain_empty", model.size() == 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fa_if.fetch_valid = 1'b0;
    fa_if.fetch_pc    = '0;
    fa_if.fetch_rdata = '0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_v0",    fa_if.instr0_valid, 0);
    check("rst_v1",    fa_if.instr1_valid, 0);
    check("rst_pc0",   fa_if.instr0_pc,    0);
    check("rst_pc1",   fa_if.instr1_pc,    0);
    check("rst_data0", fa_if.instr0_data,  0);
    check("rst_data1", fa_if.instr1_data,  0);
    check("rst_rvc",   {fa_if.instr0_rvc, fa_if.instr1_rvc}, 0);
    check("rst_ready", fa_if.fetch_ready,  1);
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // Four RVC halfwords drain as two pairs.
    send_word(32'h0000_0100, {4{16'h0001}});
    @(negedge clock);
    check("rvc_pc0_a",  fa_if.instr0_pc, 32'h100);
    check("rvc_pc1_a",  fa_if.instr1_pc, 32'h102);
    check("rvc_both_a", {fa_if.instr0_rvc, fa_if.instr1_rvc}, 2'b11);
    @(posedge clock); #1;
    @(negedge clock);
    check("rvc_pc0_b", fa_if.instr0_pc, 32'h104);
    check("rvc_pc1_b", fa_if.instr1_pc, 32'h106);
    @(posedge clock); #1;
    @(negedge clock);
    check("rvc_empty", fa_if.instr0_valid, 0);
    @(posedge clock); #1;

    // Two 32-bit instructions.
    do_clear();
    send_word(32'h0000_0200, {32'h0010_0093, 32'h0000_0013});
    @(negedge clock);
    check("w32_pc0",   fa_if.instr0_pc,   32'h200);
    check("w32_pc1",   fa_if.instr1_pc,   32'h204);
    check("w32_data0", fa_if.instr0_data, 32'h0000_0013);
    check("w32_data1", fa_if.instr1_data, 32'h0010_0093);
    @(posedge clock); #1;
    drain();

    // 32-bit instruction straddling two fetch words.
    do_clear();
    send_word(32'h0000_0306, {16'h0013, 48'h0});
    @(negedge clock);
    check("straddle_wait", fa_if.instr0_valid, 0);
    @(posedge clock); #1;
    send_word(32'h0000_0308, {16'h0001, 16'h0001, 16'h0001, 16'h0000});
    @(negedge clock);
    check("straddle_pc",   fa_if.instr0_pc,   32'h306);
    check("straddle_data", fa_if.instr0_data, 32'h0000_0013);
    @(posedge clock); #1;
    drain();

    // Backpressure under a long stall.
    do_clear();
    stall = 1'b1;
    gen_instrs(20);
    for (int w = 0; w < 4; w++) begin
      next_word(32'h0000_0600 + 32'(8 * w));
      if (w == 2) check("ready_at_12", fa_if.fetch_ready, 1);
    end
    check("ready_full", fa_if.fetch_ready, 0);
    repeat (5) @(posedge clock);
    #1;
    stall = 1'b0;
    stream(32'h0000_0620);
    drain();

    // Clear with ten halfwords held and a fetch in the same cycle.
    do_clear();
    stall = 1'b1;
    gen_instrs(12);
    next_word(32'h0000_03f4);
    next_word(32'h0000_03f8);
    next_word(32'h0000_0400);
    do_clear();
    @(negedge clock);
    check("clr_v0",    fa_if.instr0_valid, 0);
    check("clr_v1",    fa_if.instr1_valid, 0);
    check("clr_ready", fa_if.fetch_ready,  1);
    @(posedge clock); #1;
    stall = 1'b0;
    gen_instrs(4);
    next_word(32'h0000_0402);
    @(negedge clock);
    check("clr_newpc", fa_if.instr0_pc, 32'h402);
    @(posedge clock); #1;
    stream(32'h0000_0408);
    drain();

    // Long mixed stream with random stalls; pointers wrap several times.
    do_clear();
    gen_instrs(40);
    rand_stall = 1'b1;
    stream(32'h0000_0500);
    drain();

    // Reset while holding content discards it.
    do_clear();
    stall = 1'b1;
    gen_instrs(6);
    stream(32'h0000_0700);
    mon_en = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    model.delete();
    #1;
    reset = 1'b1;
    stall = 1'b0;
    @(negedge clock);
    check("midrst_v0",    fa_if.instr0_valid, 0);
    check("midrst_ready", fa_if.fetch_ready,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
